// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {LEN, DATA, CHK, DONE, ERR} state_e;

  localparam int BYTE_W        = 8;
  localparam int WORD_W        = 32;
  localparam int LEN_BYTES     = 4;
  localparam int MAX_WORDS_DEF = 16384;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian byte-to-word assembler, shared by the length header and the payload.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_vld_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_vld_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]               cnt_q;
  logic [WORD_W-BYTE_W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (byte_vld_i) begin
      cnt_q <= cnt_q + 2'd1;
    end
  end

  // Holds the first three bytes; the fourth completes the word without a register stage.
  always_ff @(posedge clk) begin
    if (byte_vld_i) begin
      sr_q <= {byte_i, sr_q[WORD_W-BYTE_W-1:BYTE_W]};
    end
  end

  assign word_vld_o = byte_vld_i && (cnt_q == 2'(LEN_BYTES - 1));
  assign word_o     = {byte_i, sr_q};

endmodule

// File: rtl/imem_prog_loader.sv
// Streams a length-prefixed image into instruction memory and holds the core in reset until done.
// Optional trailer checksum is compiled in with LOADER_CHECKSUM_EN.
module imem_prog_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_rst,
  output logic        done,
  output logic        error,
  output logic [15:0] word_count
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
  localparam state_e TAIL = CHK;
`else
  localparam state_e TAIL = DONE;
`endif

  state_e        state_q, state_d;
  logic          init_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [15:0]   wcnt_q;
  logic [15:0]   n_q;
  logic          last_q;
  logic          accept;
  logic          asm_vld;
  logic          word_vld;
  logic [31:0]   word;

  assign accept  = in_valid && in_ready;
  assign asm_vld = accept && (state_q == LEN || state_q == DATA);

  loader_word_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .byte_vld_i(asm_vld),
    .byte_i    (in_data),
    .word_vld_o(word_vld),
    .word_o    (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_chk;
  assign sum_chk = sum_q + in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state_q == DATA && accept) begin
      sum_q <= sum_q + in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= LEN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LEN: begin
        if (word_vld) begin
          if (word > MAX_W)     state_d = ERR;
          else if (word == '0)  state_d = TAIL;
          else                  state_d = DATA;
        end
      end
      // Leave DATA only once the final word's write strobe has been issued.
      DATA: if (we_q && last_q) state_d = TAIL;
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) state_d = (sum_chk == 8'd0) ? DONE : ERR;
`else
        state_d = ERR;
`endif
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    in_ready = init_q && (state_q == LEN || (state_q == DATA && !last_q) || state_q == CHK);
    done     = (state_q == DONE);
    error    = (state_q == ERR);
    cpu_rst  = (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wcnt_q  <= '0;
      n_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      init_q <= 1'b1;
      we_q   <= (state_q == DATA) && word_vld;
      if (state_q == DATA && word_vld) begin
        wdata_q <= word;
      end
      if (state_q == LEN && word_vld) begin
        n_q <= word[15:0];
      end
      if (we_q) begin
        wcnt_q <= wcnt_q + 16'd1;
      end
      // A word completes at least three cycles after the previous write, so wcnt_q is settled here.
      if (state_q == DATA && word_vld && (wcnt_q + 16'd1 == n_q)) begin
        last_q <= 1'b1;
      end else if (we_q && last_q) begin
        last_q <= 1'b0;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_wdata = wdata_q;
  assign imem_addr  = BASE_ADDR + {14'd0, wcnt_q, 2'b00};
  assign word_count = wcnt_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Directed bench for imem_prog_loader; exercises the checksum trailer when LOADER_CHECKSUM_EN is defined.
module tb_imem_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  imem_prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_we = 0;
  int b2b = 0;
  int last_we_cyc = -1;
  int fall_cyc = -1;
  logic prev_we = 1'b0;
  logic prev_cpu_rst = 1'b1;
  logic [31:0] we_addr [0:15];
  logic [31:0] we_data [0:15];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      if (n_we < 16) begin
        we_addr[n_we] = imem_addr;
        we_data[n_we] = imem_wdata;
      end
      n_we = n_we + 1;
      last_we_cyc = cyc;
      if (prev_we) b2b = b2b + 1;
    end
    if (prev_cpu_rst && !cpu_rst) fall_cyc = cyc;
    prev_cpu_rst = cpu_rst;
    prev_we = imem_we;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: byte %h never accepted", b);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[7:0], gap);
      v = v >> 8;
    end
  endtask

  task automatic load_two(input int gap);
    send_word(32'd2, gap);
    send_word(32'h0000_0013, gap);
    send_word(32'h0010_0093, gap);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h4A, gap);
`endif
    repeat (4) @(negedge clk);
  endtask

  task automatic check_two(input string tag, input int base);
    chk({tag, "_nwe"},   n_we - base, 2);
    chk({tag, "_a0"},    we_addr[base], 32'h0);
    chk({tag, "_d0"},    we_data[base], 32'h0000_0013);
    chk({tag, "_a1"},    we_addr[base+1], 32'h4);
    chk({tag, "_d1"},    we_data[base+1], 32'h0010_0093);
    chk({tag, "_wc"},    word_count, 16'd2);
    chk({tag, "_done"},  done, 1'b1);
    chk({tag, "_cpu"},   cpu_rst, 1'b0);
    chk({tag, "_err"},   error, 1'b0);
    chk({tag, "_rdy"},   in_ready, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    chk({tag, "_fall"},  32'(fall_cyc > last_we_cyc + 1), 1);
`else
    chk({tag, "_fall"},  fall_cyc, last_we_cyc + 1);
`endif
  endtask

  int base;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rdy",   in_ready, 1'b0);
    chk("rst_we",    imem_we, 1'b0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_cpu",   cpu_rst, 1'b1);
    chk("rst_done",  done, 1'b0);
    chk("rst_err",   error, 1'b0);
    chk("rst_wc",    word_count, 16'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 1'b1);

    // Two-word image, back-to-back bytes
    base = n_we;
    load_two(0);
    check_two("basic", base);

    // Same image with gaps between bytes
    pulse_rst();
    chk("reload_cpu", cpu_rst, 1'b1);
    chk("reload_done", done, 1'b0);
    base = n_we;
    load_two(1);
    check_two("gapped", base);

    // Oversized header
    pulse_rst();
    base = n_we;
    send_word(32'h0000_4001, 0);
    repeat (3) @(negedge clk);
    chk("big_err", error, 1'b1);
    chk("big_rdy", in_ready, 1'b0);
    chk("big_cpu", cpu_rst, 1'b1);
    chk("big_nwe", n_we - base, 0);

    // Largest legal header is accepted
    pulse_rst();
    send_word(32'h0000_4000, 0);
    repeat (2) @(negedge clk);
    chk("max_err", error, 1'b0);
    chk("max_rdy", in_ready, 1'b1);
    chk("max_cpu", cpu_rst, 1'b1);

    // Empty image
    pulse_rst();
    base = n_we;
    send_word(32'h0, 0);
`ifdef LOADER_CHECKSUM_EN
    @(negedge clk);
    chk("empty_wait_cpu", cpu_rst, 1'b1);
    send_byte(8'h00, 0);
`endif
    repeat (2) @(negedge clk);
    chk("empty_done", done, 1'b1);
    chk("empty_cpu",  cpu_rst, 1'b0);
    chk("empty_nwe",  n_we - base, 0);

    // Abort after two payload bytes, then a full reload
    pulse_rst();
    base = n_we;
    send_word(32'd2, 0);
    send_byte(8'h13, 0);
    send_byte(8'h00, 0);
    pulse_rst();
    chk("abort_wc",  word_count, 16'd0);
    chk("abort_nwe", n_we - base, 0);
    chk("abort_rdy", in_ready, 1'b1);
    chk("abort_cpu", cpu_rst, 1'b1);
    base = n_we;
    load_two(0);
    check_two("after_abort", base);

`ifdef LOADER_CHECKSUM_EN
    pulse_rst();
    send_word(32'd1, 0);
    send_word(32'h0000_0013, 0);
    send_byte(8'hED, 0);
    repeat (2) @(negedge clk);
    chk("csum_ok_done", done, 1'b1);
    chk("csum_ok_cpu",  cpu_rst, 1'b0);

    pulse_rst();
    send_word(32'd1, 0);
    send_word(32'h0000_0013, 0);
    send_byte(8'hEE, 0);
    repeat (2) @(negedge clk);
    chk("csum_bad_err", error, 1'b1);
    chk("csum_bad_cpu", cpu_rst, 1'b1);
    chk("csum_bad_done", done, 1'b0);
`endif

    chk("no_b2b_we", b2b, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/imem_prog_loader.md
Name: imem_prog_loader

Overview:
- Boot-time program loader directly upstream of the single-cycle RV32 core's instruction memory.
- Accepts a byte stream (length header, payload words, optional checksum) over a valid/ready interface.
- Assembles little-endian 32-bit instructions and writes them into instruction memory.
- Holds the core in reset until the image is fully written, then releases it so execution starts at PC 0.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be 4-byte aligned.
- MAX_WORDS, 16384: largest accepted image length in words; larger headers raise an error.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  loader can accept a byte.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  32  byte address of the write, word aligned.
- imem_wdata  out  32  instruction word being written.
- cpu_rst  out  1  reset to the core; high while loading or on error.
- done  out  1  image loaded, core released; sticky.
- error  out  1  load failed; sticky.
- word_count  out  16  words written so far.

Behaviour:
- Reset values while rst=1 and in the cycle after it:
  - in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_rst=1, done=0, error=0, word_count=0.
  - State enters LEN with the byte counter at 0.
- Byte transfer occurs on a rising edge with in_valid && in_ready. in_valid without in_ready is held off; no bytes are dropped.
- States:
  - LEN: in_ready=1. Take 4 bytes as N, little-endian, low byte first.
    - N > MAX_WORDS -> ERR.
    - N == 0 -> CHK if the optional feature is compiled in, else DONE.
    - Otherwise -> DATA.
  - DATA: in_ready=1. Shift bytes into a word, little-endian.
    - On the 4th byte, the next cycle drives imem_we=1 with imem_addr = BASE_ADDR + 4*word_count and imem_wdata = the assembled word.
    - word_count increments in that same write cycle.
    - in_ready stays 1 during the write cycle; the next word's bytes are assembled in parallel.
  - After the write of word N: -> CHK if enabled, else DONE. No further bytes are accepted once the final word's 4th byte has been taken.
  - CHK: described under Optional Feature.
  - DONE: in_ready=0, done=1. cpu_rst falls on the cycle after the last imem_we pulse; when N=0, on the cycle after the header completes. Held until rst.
  - ERR: in_ready=0, error=1, cpu_rst=1, imem_we=0. Held until rst.
- Boundaries:
  - Only one imem_we pulse per word, never two back-to-back.
  - word_count saturates logically at N; it never exceeds N.
  - Address arithmetic is 32-bit and wraps modulo 2^32 without error.
  - rst mid-load aborts immediately and discards partial words and header bytes. Words already written to memory are not cleared.
  - rst while in DONE re-asserts cpu_rst the next cycle and reloads.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum covers all payload bytes (header excluded), modulo 256.
  - After word N, the CHK state accepts one trailer byte.
  - If (sum + trailer) mod 256 == 0 -> DONE, with cpu_rst falling on the following cycle.
  - Otherwise -> ERR.
- When undefined:
  - No CHK state and no trailer byte.
  - DATA goes straight to DONE; the checksum register is absent.

Decomposition:
- Package loader_pkg holds:
  - state enum {LEN, DATA, CHK, DONE, ERR}.
  - BYTE_W=8, WORD_W=32, LEN_BYTES=4.
  - The default MAX_WORDS constant.
- Sub-module loader_word_asm:
  - 2-bit byte counter and a little-endian shift register.
  - Emits word_valid for one cycle with the word.
  - Reused for both the length header and the payload.

Test Plan:
- Header 02 00 00 00, payload 13 00 00 00 / 93 00 10 00 -> imem_we at 0x0 data 0x00000013, then 0x4 data 0x00100093; cpu_rst falls the cycle after the second write; done=1; word_count=2.
- Same stream with in_valid toggling every other cycle and in_ready forced low by stalls -> identical writes and final state; no lost or duplicated bytes.
- Header 01 40 00 00 (16385 > MAX_WORDS) -> error=1, in_ready=0, cpu_rst stays 1, no imem_we.
- Header 00 00 00 00 -> done=1 and cpu_rst=0 without any imem_we; with LOADER_CHECKSUM_EN, trailer 00 is required first.
- LOADER_CHECKSUM_EN, one word 13 00 00 00:
  - Trailer ED -> done=1.
  - Trailer EE -> error=1, cpu_rst=1.
- rst pulsed after 2 payload bytes of word 0 -> state back to LEN, word_count=0, no write issued; a full reload then completes normally.
